hram_rd_streamer: RTL and testbench

Read-return stage between the HyperRAM controller and the serial transmitter. Captures each 32-bit word the controller presents on `rd_d`/`rd_rdy` into a small FIFO, then serializes the words MSB-byte-first into the `uart_tx` start/ready handshake. This lets burst reads (`rd_num_dwords` > 0) return every word to the host without being overwritten in a single holding register.

---
 rtl/hram_rd_streamer_if.sv | 11 +
 rtl/hram_rd_streamer.sv | 115 +++++++++++
 tb/tb_hram_rd_streamer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hram_rd_streamer_if.sv
// hram_rd_streamer_if: read-word input and uart_tx handshake bundle for the read-return streamer.
// The slave view belongs to the streamer and the master view to the controller/UART side.
interface hram_rd_streamer_if;
    logic [31:0] rd_d;
    logic        rd_rdy;
    logic        tx_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    modport master (output rd_d, rd_rdy, tx_ready, input tx_start, tx_data);
    modport slave (input rd_d, rd_rdy, tx_ready, output tx_start, tx_data);
endinterface

// File: rtl/hram_rd_streamer.sv
// hram_rd_streamer: buffers HyperRAM read words in a FIFO and serializes them MSB byte first to uart_tx.
// tx_start is combinational from START and tx_ready, which gives the two-cycle first-byte latency.
module hram_rd_streamer #(
    parameter int DEPTH         = 16,
    parameter int START_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear,
    hram_rd_streamer_if.slave        bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     empty,
    output logic                     overflow,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_LOW, WAIT_HIGH} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   shift_q, shift_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   mem [DEPTH];
    logic          full, pop, push;

    assign full = count_q == FULL_CNT;
    assign pop  = state_q == IDLE && count_q != '0 && !clear;
    // A full FIFO still takes a word when the serializer pops in the same cycle.
    assign push = bus.rd_rdy && (!full || pop) && !clear;

    always_comb begin
        wptr_d  = clear ? '0 : wptr_q + AW'(push);
        rptr_d  = clear ? '0 : rptr_q + AW'(pop);
        count_d = clear ? '0 : count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        ovf_d   = !clear && (ovf_q || (bus.rd_rdy && full && !pop));
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bcnt_d       = bcnt_q;
        tmo_d        = tmo_q;
        bus.tx_start = 1'b0;
        case (state_q)
            IDLE: if (pop) begin
                shift_d = mem[rptr_q];
                bcnt_d  = 2'd3;
                state_d = START;
            end
            START: if (bus.tx_ready) begin
                bus.tx_start = 1'b1;
                tmo_d        = '0;
                state_d      = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!bus.tx_ready) state_d = WAIT_HIGH;
                else if (tmo_q == TMO_LAST) state_d = START;
                else tmo_d = tmo_q + 1'b1;
            end
            WAIT_HIGH: if (bus.tx_ready) begin
                // The last byte stays in the shift register so tx_data holds until the next pop.
                if (bcnt_q == 2'd0) state_d = IDLE;
                else begin
                    shift_d = {shift_q[23:0], 8'h00};
                    bcnt_d  = bcnt_q - 2'd1;
                    state_d = START;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d      = IDLE;
            bus.tx_start = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            shift_q <= '0;
            bcnt_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= bus.rd_d;
    end

    assign bus.tx_data = shift_q[31:24];
    assign fifo_count  = count_q;
    assign empty       = count_q == '0;
    assign overflow    = ovf_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_hram_rd_streamer.sv
// tb_hram_rd_streamer: scoreboard bench; stimulus queues expected bytes, a negedge monitor pops them on tx_start.
// A small UART model drives tx_ready with configurable busy time, stalling and ignored starts.
module tb_hram_rd_streamer;
    localparam int TO = 4;

    logic clk = 1'b0, rstn = 1'b0, clear = 1'b0;
    always #5 clk = ~clk;

    hram_rd_streamer_if bus();
    logic [4:0] fifo_count;
    logic empty, overflow, busy;

    hram_rd_streamer #(.DEPTH(16), .START_TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .clear(clear), .bus(bus),
        .fifo_count(fifo_count), .empty(empty), .overflow(overflow), .busy(busy)
    );

    int checks = 0, errors = 0;
    int cyc = 0, starts = 0, retries = 0, ign_cyc = 0;
    int uart_delay = 10, ignore_cnt = 0;
    logic stall = 1'b0, ign_pending = 1'b0, prev_start = 1'b0;
    logic [7:0] ign_data = 8'h00;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: ignored starts are remembered so the retry can be timed and matched.
    always @(negedge clk) begin
        if (bus.tx_start) begin
            chk("start_back_to_back", 32'(prev_start), 32'd0);
            chk("start_while_not_ready", 32'(bus.tx_ready), 32'd1);
            if (ignore_cnt > 0) begin
                ign_cyc     = cyc;
                ign_data    = bus.tx_data;
                ign_pending = 1'b1;
            end else begin
                if (ign_pending) begin
                    chk("retry_gap", 32'(cyc - ign_cyc), 32'(TO + 1));
                    chk("retry_data", 32'(bus.tx_data), 32'(ign_data));
                    ign_pending = 1'b0;
                    retries++;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got byte %0h, required no start", bus.tx_data);
                end else chk("byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                starts++;
            end
        end
        prev_start = bus.tx_start;
    end

    initial begin
        int low_cnt;
        logic started;
        low_cnt = 0;
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            started = bus.tx_start;
            @(posedge clk);
            #1;
            if (stall) bus.tx_ready = 1'b0;
            else if (started && ignore_cnt > 0) ignore_cnt--;
            else if (started) begin
                low_cnt = uart_delay;
                bus.tx_ready = 1'b0;
            end else if (low_cnt > 0) begin
                low_cnt--;
                if (low_cnt == 0) bus.tx_ready = 1'b1;
            end else bus.tx_ready = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] w, input bit keep = 1'b1);
        bus.rd_d   = w;
        bus.rd_rdy = 1'b1;
        if (keep) for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
        cycles(1);
        bus.rd_rdy = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (k < budget && !(exp_q.size() == 0 && empty && !busy)) begin
            cycles(1);
            k++;
        end
        chk(name, 32'(k < budget), 32'd1);
    endtask

    task automatic wait_starts(input string name, input int target);
        int k = 0;
        while (k < 500 && starts < target) begin
            cycles(1);
            k++;
        end
        chk(name, 32'(starts >= target), 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        chk({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int s0;
        bus.rd_d   = '0;
        bus.rd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rstn = 1'b1;
        cycles(2);

        // Single word with first-byte latency.
        uart_delay = 10;
        bus.rd_d   = 32'hDEADBEEF;
        bus.rd_rdy = 1'b1;
        for (int b = 3; b >= 0; b--) exp_q.push_back(bus.rd_d[b*8 +: 8]);
        @(negedge clk);
        chk("lat_n_start", 32'(bus.tx_start), 32'd0);
        @(posedge clk);
        #1;
        bus.rd_rdy = 1'b0;
        @(negedge clk);
        chk("lat_n1_start", 32'(bus.tx_start), 32'd0);
        chk("lat_n1_count", 32'(fifo_count), 32'd1);
        @(negedge clk);
        chk("lat_n2_start", 32'(bus.tx_start), 32'd1);
        @(posedge clk);
        #1;
        drain("single_drain", 1000);
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_busy", 32'(busy), 32'd0);

        // Burst fill with a stalled UART, then overflow.
        stall = 1'b1;
        cycles(2);
        for (int i = 0; i < 16; i++) send(32'(i));
        chk("burst_count15", 32'(fifo_count), 32'd15);
        chk("burst_ovf0", 32'(overflow), 32'd0);
        send(32'h10);
        chk("burst_count16", 32'(fifo_count), 32'd16);
        chk("burst17_ovf0", 32'(overflow), 32'd0);
        send(32'h11, 1'b0);
        chk("burst18_count", 32'(fifo_count), 32'd16);
        chk("burst18_ovf1", 32'(overflow), 32'd1);
        stall = 1'b0;
        drain("burst_drain", 4000);
        chk("burst_ovf_sticky", 32'(overflow), 32'd1);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        chk("clear_ovf", 32'(overflow), 32'd0);

        // Pointer wrap with a fast UART.
        uart_delay = 2;
        for (int i = 0; i < 40; i++) begin
            send({8'(i), 8'(~i), 8'(i ^ 8'h5A), 8'(i + 1)});
            cycles(29);
        end
        drain("wrap_drain", 500);
        chk("wrap_ovf", 32'(overflow), 32'd0);

        // Start timeout: the first start pulse is ignored.
        uart_delay = 3;
        ignore_cnt = 1;
        send(32'hA5B6C7D8);
        drain("timeout_drain", 500);
        chk("timeout_retries", 32'(retries), 32'd1);

        // Clear during the second byte with three words queued.
        uart_delay = 10;
        s0 = starts;
        send(32'h11223344);
        send(32'hAAAA0001);
        send(32'hAAAA0002);
        send(32'hAAAA0003);
        wait_starts("clear_wait", s0 + 2);
        cycles(2);
        clear = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("clear_no_start", 32'(bus.tx_start), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_count", 32'(fifo_count), 32'd0);
        chk("clear_ovf2", 32'(overflow), 32'd0);
        chk("clear_empty", 32'(empty), 32'd1);
        cycles(40);
        send(32'hCAFEF00D);
        drain("after_clear_drain", 500);

        // Asynchronous reset mid-word.
        s0 = starts;
        send(32'h55667788);
        wait_starts("reset_wait", s0 + 1);
        cycles(3);
        #1;
        rstn = 1'b0;
        exp_q.delete();
        #1;
        chk_reset("async_reset");
        @(posedge clk);
        #1;
        cycles(2);
        rstn = 1'b1;
        cycles(30);
        send(32'h01020304);
        drain("after_reset_drain", 500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
